// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: status codes,
// exponent bias helper and operand field layouts.
package fp_pkg;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;
    localparam logic [1:0] ERR_NAN  = 2'd3;

    // Field layout of the default (bfloat16) operand.
    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Combinational back end of the multiplier: operand classification, 1-bit
// normalisation, rounding (RNE when FP_MUL_RNE_EN is defined, else truncation).
module fp_mul_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [2*MAN_W+1:0]     prod,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [1:0]             error
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [EW-1:0]    BIAS_W = EW'(bias(EXP_W));
    localparam logic [W-1:0]     QNAN   = {1'b0, E_ONES, MAN_W'(1) << (MAN_W - 1)};

`ifdef FP_MUL_RNE_EN
    localparam bit RNE_EN = 1'b1;
`else
    localparam bit RNE_EN = 1'b0;
`endif

    function automatic fp_class_t classify(input logic [W-1:0] x);
        fp_class_t c;
        c.zero = (x[W-2 -: EXP_W] == '0);
        c.inf  = (x[W-2 -: EXP_W] == E_ONES) && (x[MAN_W-1:0] == '0);
        c.nan  = (x[W-2 -: EXP_W] == E_ONES) && (x[MAN_W-1:0] != '0);
        return c;
    endfunction

    fp_class_t              ca, cb;
    logic                   sign, hi, guard, sticky, round_up, ovf, unf;
    logic [PW-2:0]          norm;
    logic [MAN_W-1:0]       mant;
    logic [MAN_W:0]         mant_r;
    logic signed [EW-1:0]   exp_fin;

    assign ca = classify(a);
    assign cb = classify(b);

    always_comb begin
        sign = a[W-1] ^ b[W-1];
        // Significand product lies in [1,4); drop the leading one after an optional 1-bit shift.
        hi   = prod[PW-1];
        norm = hi ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        mant   = norm[PW-2 -: MAN_W];
        guard  = norm[PW-2-MAN_W];
        sticky = |norm[PW-3-MAN_W:0];
        round_up = RNE_EN & guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + (MAN_W+1)'(round_up);
        // A rounding carry leaves mant_r[MAN_W-1:0] all zero, so only the exponent moves.
        exp_fin  = EW'(a[W-2 -: EXP_W]) + EW'(b[W-2 -: EXP_W]) - BIAS_W
                 + EW'(hi) + EW'(mant_r[MAN_W]);
        ovf = !exp_fin[EW-1] && (exp_fin[EW-2:0] >= {1'b0, E_ONES});
        unf = exp_fin[EW-1] || (exp_fin == '0);

        result = {sign, exp_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
        error  = ERR_NONE;
        if (ca.nan || cb.nan || (ca.inf && cb.zero) || (cb.inf && ca.zero)) begin
            result = QNAN;
            error  = ERR_NAN;
        end else if (ca.inf || cb.inf) begin
            result = {sign, E_ONES, MAN_W'(0)};
        end else if (ca.zero || cb.zero) begin
            result = {sign, (EXP_W+MAN_W)'(0)};
        end else if (ovf) begin
            result = {sign, E_ONES, MAN_W'(0)};
            error  = ERR_OVF;
        end else if (unf) begin
            result = {sign, (EXP_W+MAN_W)'(0)};
            error  = ERR_UNF;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier with valid/ready handshake on both ports.
// Build option: define FP_MUL_RNE_EN for round-to-nearest-even (default truncates).
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 7,
    parameter int STAGES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in1,
    input  logic [EXP_W+MAN_W:0]   in2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [1:0]             error
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int DW = 2 * W + PW;

    logic [PW-1:0]      prod_in;
    logic [STAGES-1:0]  stage_valid;
    logic [STAGES-1:0]  stage_en;
    logic [DW-1:0]      stage_data [STAGES];
    logic               running;
    logic               accept;
    logic [W-1:0]       last_a, last_b, nr_result;
    logic [PW-1:0]      last_prod;
    logic [1:0]         nr_error;

    assign prod_in = PW'({1'b1, in1[MAN_W-1:0]}) * PW'({1'b1, in2[MAN_W-1:0]});

    // A stage may load when it is empty or its contents move on this edge.
    always_comb begin
        logic chain;
        // NOTE: every variable gets a value on every path; a missed default would infer a latch.
        stage_en = '0;
        chain    = ~stage_valid[STAGES-1] | out_ready;
        stage_en[STAGES-1] = chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            chain       = ~stage_valid[k] | chain;
            stage_en[k] = chain;
        end
    end

    // running holds in_ready low until the first edge after reset is released.
    assign in_ready = running & stage_en[0];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            stage_valid <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its neighbour's pre-edge value.
            running <= 1'b1;
            if (stage_en[0]) stage_valid[0] <= accept;
            for (int k = 1; k < STAGES; k++) begin
                if (stage_en[k]) stage_valid[k] <= stage_valid[k-1];
            end
        end
    end

    // NOTE: payload registers are left unreset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (accept) stage_data[0] <= {in1, in2, prod_in};
        for (int k = 1; k < STAGES; k++) begin
            if (stage_en[k] && stage_valid[k-1]) stage_data[k] <= stage_data[k-1];
        end
    end

    assign {last_a, last_b, last_prod} = stage_data[STAGES-1];

    fp_mul_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .a      (last_a),
        .b      (last_b),
        .prod   (last_prod),
        .result (nr_result),
        .error  (nr_error)
    );

    // Masking with out_valid keeps out/error at zero until real data arrives.
    assign out_valid = stage_valid[STAGES-1];
    assign out       = out_valid ? nr_result : '0;
    assign error     = out_valid ? nr_error : ERR_NONE;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed and random-stream bench for fp_mul_pipe at bfloat16 defaults.
module tb_fp_mul_pipe;
    import fp_pkg::*;

    localparam int STAGES = 3;
    localparam int N_RAND = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [15:0] in1 = '0, in2 = '0, out;
    logic [1:0]  error;
    int          total = 0;
    int          bad = 0;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Reference product via real arithmetic; returns {error, result}.
    function automatic logic [17:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        bf16_t x, y;
        logic  s, az, bz, ai, bi, an, bn;
        real   p, frac, rem;
        int    e, fi;
        x = a;
        y = b;
        s  = x.sign ^ y.sign;
        az = (x.exp == 8'h00);
        bz = (y.exp == 8'h00);
        ai = (x.exp == 8'hFF) && (x.man == 7'h0);
        bi = (y.exp == 8'hFF) && (y.man == 7'h0);
        an = (x.exp == 8'hFF) && (x.man != 7'h0);
        bn = (y.exp == 8'hFF) && (y.man != 7'h0);
        if (an || bn || (ai && bz) || (bi && az)) return {ERR_NAN, 16'h7FC0};
        if (ai || bi) return {ERR_NONE, s, 8'hFF, 7'h00};
        if (az || bz) return {ERR_NONE, s, 15'h0000};
        p = (128.0 + x.man) * (128.0 + y.man) / 16384.0;
        e = int'(x.exp) + int'(y.exp) - 127;
        if (p >= 2.0) begin
            p = p / 2.0;
            e = e + 1;
        end
        frac = (p - 1.0) * 128.0;
        fi   = $rtoi(frac);
        rem  = frac - fi;
`ifdef FP_MUL_RNE_EN
        if (rem > 0.5 || (rem == 0.5 && (fi % 2) == 1)) fi = fi + 1;
`else
        if (rem < 0.0) fi = 0;
`endif
        if (fi == 128) begin
            fi = 0;
            e  = e + 1;
        end
        if (e >= 255) return {ERR_OVF, s, 8'hFF, 7'h00};
        if (e <= 0) return {ERR_UNF, s, 15'h0000};
        return {ERR_NONE, s, e[7:0], fi[6:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] x;
        x = 16'($urandom);
        if (($urandom % 4) != 0) x[14:7] = 8'($urandom_range(60, 195));
        return x;
    endfunction

    // Offers one pair with out_ready=1 and waits for its result; lat=-1 on timeout.
    task automatic send_one(input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] r, output logic [1:0] e, output int lat);
        int n;
        r = 16'hDEAD;
        e = 2'b00;
        lat = -1;
        @(negedge clk);
        in_valid = 1'b1; in1 = a; in2 = b; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                r = out;
                e = error;
                lat = c;
                return;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, out, error} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b ready=%b out=%h err=%0d, want all 0",
                     out_valid, in_ready, out, error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, out} !== {1'b1, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL reset_release: ready=%b valid=%b out=%h, want 1 0 0000",
                     in_ready, out_valid, out);
        end
    endtask

    task automatic test_latency();
        logic [15:0] r;
        logic [1:0]  e;
        int          lat;
        send_one(16'h3F80, 16'h4000, r, e, lat);
        total++;
        if ({r, e} !== {16'h4000, ERR_NONE}) begin
            bad++;
            $display("FAIL one_times_two: got %h/%0d, want 4000/0", r, e);
        end
        total++;
        if (lat !== STAGES) begin
            bad++;
            $display("FAIL latency: got %0d, want %0d", lat, STAGES);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] r, want;
        logic [1:0]  e;
        int          lat;
`ifdef FP_MUL_RNE_EN
        want = 16'h4012;
`else
        want = 16'h4011;
`endif
        send_one(16'h3FC1, 16'h3FC1, r, e, lat);
        total++;
        if ({r, e} !== {want, ERR_NONE}) begin
            bad++;
            $display("FAIL round_3fc1: got %h/%0d, want %h/0", r, e, want);
        end
    endtask

    task automatic test_special();
        logic [15:0] va [12], vb [12], vr [12], r;
        logic [1:0]  ve [12], e;
        int          lat;
        va[0]  = 16'h7F00; vb[0]  = 16'h7F00; vr[0]  = 16'h7F80; ve[0]  = ERR_OVF;
        va[1]  = 16'h0080; vb[1]  = 16'h0080; vr[1]  = 16'h0000; ve[1]  = ERR_UNF;
        va[2]  = 16'h7F80; vb[2]  = 16'h0000; vr[2]  = 16'h7FC0; ve[2]  = ERR_NAN;
        va[3]  = 16'hFF80; vb[3]  = 16'h4000; vr[3]  = 16'hFF80; ve[3]  = ERR_NONE;
        va[4]  = 16'h8000; vb[4]  = 16'h4000; vr[4]  = 16'h8000; ve[4]  = ERR_NONE;
        va[5]  = 16'h0001; vb[5]  = 16'h3F80; vr[5]  = 16'h0000; ve[5]  = ERR_NONE;
        va[6]  = 16'h7FC1; vb[6]  = 16'h3F80; vr[6]  = 16'h7FC0; ve[6]  = ERR_NAN;
        va[7]  = 16'h0080; vb[7]  = 16'h3F80; vr[7]  = 16'h0080; ve[7]  = ERR_NONE;
        va[8]  = 16'h8080; vb[8]  = 16'h3F00; vr[8]  = 16'h8000; ve[8]  = ERR_UNF;
        va[10] = 16'hBF80; vb[10] = 16'h4040; vr[10] = 16'hC040; ve[10] = ERR_NONE;
        va[11] = 16'h7F7F; vb[11] = 16'h3F80; vr[11] = 16'h7F7F; ve[11] = ERR_NONE;
        va[9]  = 16'h7F35; vb[9]  = 16'h3FB5;
`ifdef FP_MUL_RNE_EN
        vr[9] = 16'h7F80; ve[9] = ERR_OVF;
`else
        vr[9] = 16'h7F7F; ve[9] = ERR_NONE;
`endif
        for (int i = 0; i < 12; i++) begin
            send_one(va[i], vb[i], r, e, lat);
            total++;
            if ({r, e} !== {vr[i], ve[i]} || lat !== STAGES) begin
                bad++;
                $display("FAIL special_%0d: %h*%h got %h/%0d lat %0d, want %h/%0d lat %0d",
                         i, va[i], vb[i], r, e, lat, vr[i], ve[i], STAGES);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pa [5], pb [5], pr [5];
        logic [15:0] held;
        int          n_in, n_out;
        pa[0] = 16'h3F80; pb[0] = 16'h3F80; pr[0] = 16'h3F80;
        pa[1] = 16'h4000; pb[1] = 16'h4000; pr[1] = 16'h4080;
        pa[2] = 16'h4040; pb[2] = 16'h4000; pr[2] = 16'h40C0;
        pa[3] = 16'hBF80; pb[3] = 16'h4040; pr[3] = 16'hC040;
        pa[4] = 16'h3F00; pb[4] = 16'h3F00; pr[4] = 16'h3E80;
        n_in = 0;
        n_out = 0;
        held = 16'h0000;
        for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 8);
            in_valid  = (n_in < 5);
            in1 = pa[n_in % 5];
            in2 = pb[n_in % 5];
            #1;
            if (cyc == 3) held = out;
            if (cyc == 7) begin
                total++;
                if (n_in !== 3 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_fill: accepted %0d ready %b, want 3 0", n_in, in_ready);
                end
                total++;
                if (out_valid !== 1'b1 || out !== held || out !== pr[0]) begin
                    bad++;
                    $display("FAIL bp_hold: valid %b out %h, want 1 %h", out_valid, out, pr[0]);
                end
            end
            if (out_ready && n_out > 0 && n_out < 5) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_gap: no result at cycle %0d after %0d results", cyc, n_out);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (out !== pr[n_out]) begin
                    bad++;
                    $display("FAIL bp_order_%0d: got %h, want %h", n_out, out, pr[n_out]);
                end
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
        end
        in_valid = 1'b0;
        total++;
        if (n_out !== 5) begin
            bad++;
            $display("FAIL bp_count: got %0d results, want 5", n_out);
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] r;
        logic [1:0]  e;
        int          lat, stale;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in1 = 16'h4000; in2 = 16'h4000;
        @(negedge clk);
        in1 = 16'h4040; in2 = 16'h4000;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, out, error} !== 20'h0) begin
            bad++;
            $display("FAIL midreset_outputs: valid=%b ready=%b out=%h err=%0d, want all 0",
                     out_valid, in_ready, out, error);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_release: out_valid %b, want 0", out_valid);
        end
        send_one(16'h3F00, 16'h4000, r, e, lat);
        total++;
        if ({r, e} !== {16'h3F80, ERR_NONE} || lat !== STAGES) begin
            bad++;
            $display("FAIL midreset_next: got %h/%0d lat %0d, want 3f80/0 lat %0d",
                     r, e, lat, STAGES);
        end
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        total++;
        if (stale !== 0) begin
            bad++;
            $display("FAIL midreset_stale: %0d extra results, want 0", stale);
        end
    endtask

    task automatic test_random_stream();
        logic [17:0] q [$];
        logic [17:0] want, held;
        logic        stalled;
        int          sent, got;
        sent = 0;
        got = 0;
        stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 6000 && got < N_RAND; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < N_RAND) && (($urandom % 4) != 0);
            in1       = rand_op();
            in2       = rand_op();
            out_ready = (($urandom % 3) != 0);
            #1;
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || {error, out} !== held) begin
                    bad++;
                    $display("FAIL rand_stall: valid %b out %h/%0d, want 1 %h/%0d",
                             out_valid, out, error, held[15:0], held[17:16]);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(in1, in2));
                sent++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra: unexpected result %h", out);
                end else begin
                    want = q.pop_front();
                    if ({error, out} !== want) begin
                        bad++;
                        $display("FAIL rand_%0d: got %h/%0d, want %h/%0d",
                                 got, out, error, want[15:0], want[17:16]);
                    end
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = {error, out};
        end
        in_valid = 1'b0;
        total++;
        if (got !== N_RAND || q.size() != 0) begin
            bad++;
            $display("FAIL rand_count: got %0d results, %0d pending, want %0d and 0",
                     got, q.size(), N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_special();
        test_backpressure();
        test_reset_midflight();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
